ad5543_tx: RTL and testbench



---
 rtl/ad5543_tx.sv | 167 ++++++++++++++++
 tb/tb_ad5543_tx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad5543_tx.sv
// AD5543 serial DAC transmitter: AXI-Stream sample FIFO feeding one 16-bit SPI frame per tick.
// Optional AD5543_TX_OFFSET_BIN_EN converts two's complement samples to offset binary.
module ad5543_tx #(
    parameter int unsigned DW            = 16,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned CLK_DIV       = 2,
    parameter int unsigned SAMPLE_PERIOD = 200,
    parameter int unsigned LOW_THRESH    = 4
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic          en,
    input  logic [DW-1:0] s_axis_tdata,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    output logic          sclk,
    output logic          sdi,
    output logic          cs_n,
    output logic          fifo_irq,
    output logic          underrun,
    output logic          busy
);

    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TW  = $clog2(SAMPLE_PERIOD);
    localparam int unsigned DVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned EW  = $clog2(2 * DW);

    typedef enum logic [1:0] {StIdle, StShift, StCsh} state_e;

    logic [DW-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic           tready_q, irq_q;
    logic [TW-1:0]  tick_q, tick_d;
    state_e         state_q, state_d;
    logic [DW-1:0]  shreg_q, shreg_d;
    logic [DVW-1:0] div_q, div_d;
    logic [EW-1:0]  edge_q, edge_d;
    logic           sclk_q, sclk_d;
    logic           cs_n_q, cs_n_d;
    logic           underrun_q, underrun_d;
    logic           push, pop, tick;
    logic [DW-1:0]  rd_data, load_word;

    assign push    = s_axis_tvalid && tready_q;
    assign tick    = en && (tick_q == TW'(SAMPLE_PERIOD - 1));
    assign rd_data = mem_q[rd_ptr_q];

`ifdef AD5543_TX_OFFSET_BIN_EN
    assign load_word = {~rd_data[DW-1], rd_data[DW-2:0]};
`else
    assign load_word = rd_data;
`endif

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        tick_d = (!en || tick) ? '0 : tick_q + 1'b1;
    end

    // sdi is the shift register MSB; shifting on every fall leaves it zero after the last bit.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        div_d      = div_q;
        edge_d     = edge_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        underrun_d = 1'b0;
        pop        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shreg_d = load_word;
                        cs_n_d  = 1'b0;
                        sclk_d  = 1'b0;
                        div_d   = '0;
                        edge_d  = '0;
                        state_d = StShift;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end
            end
            StShift: begin
                if (div_q == DVW'(CLK_DIV - 1)) begin
                    div_d  = '0;
                    edge_d = edge_q + 1'b1;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d  = 1'b0;
                        shreg_d = {shreg_q[DW-2:0], 1'b0};
                        if (edge_q == EW'(2 * DW - 1)) begin
                            cs_n_d  = 1'b1;
                            state_d = StCsh;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StCsh: begin
                if (div_q == DVW'(CLK_DIV - 1)) begin
                    div_d   = '0;
                    state_d = StIdle;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tready_q   <= 1'b0;
            irq_q      <= 1'b0;
            tick_q     <= '0;
            state_q    <= StIdle;
            shreg_q    <= '0;
            div_q      <= '0;
            edge_q     <= '0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            underrun_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            tready_q   <= (count_d != CW'(FIFO_DEPTH));
            irq_q      <= en && (count_q <= CW'(LOW_THRESH));
            tick_q     <= tick_d;
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            div_q      <= div_d;
            edge_q     <= edge_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            underrun_q <= underrun_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (push) mem_q[wr_ptr_q] <= s_axis_tdata;
    end

    assign s_axis_tready = tready_q;
    assign sclk          = sclk_q;
    assign sdi           = shreg_q[DW-1];
    assign cs_n          = cs_n_q;
    assign fifo_irq      = irq_q;
    assign underrun      = underrun_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_ad5543_tx.sv
// Self-checking bench for ad5543_tx: queue-based FIFO/tick model plus an AD5543-style receiver.
module tb_ad5543_tx;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int CD    = 2;
    localparam int SP    = 200;
    localparam int LT    = 4;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic          areset, en, tvalid;
    logic [DW-1:0] tdata;
    logic          tready, sclk, sdi, cs_n, fifo_irq, underrun, busy;

    ad5543_tx #(
        .DW            (DW),
        .FIFO_DEPTH    (DEPTH),
        .CLK_DIV       (CD),
        .SAMPLE_PERIOD (SP),
        .LOW_THRESH    (LT)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .en            (en),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .sclk          (sclk),
        .sdi           (sdi),
        .cs_n          (cs_n),
        .fifo_irq      (fifo_irq),
        .underrun      (underrun),
        .busy          (busy)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] xform(input logic [DW-1:0] d);
`ifdef AD5543_TX_OFFSET_BIN_EN
        return d ^ 16'h8000;
`else
        return d;
`endif
    endfunction

    // DAC receiver: sample sdi on sclk rise while selected, latch on cs_n rise after 16 bits.
    logic [DW-1:0] rx_shift  = '0;
    logic [DW-1:0] recv_data = '0;
    int            rx_bits   = 0;
    int            rises     = 0;
    longint        t_fall    = 0;
    logic [DW-1:0] rx_q[$];
    int            len_q[$];

    initial forever begin
        @(negedge cs_n);
        rx_bits = 0;
        rises   = 0;
        t_fall  = $time;
    end

    initial forever begin
        @(posedge sclk);
        if (cs_n === 1'b0) begin
            rx_shift = {rx_shift[DW-2:0], sdi};
            rx_bits++;
            rises++;
        end
    end

    initial forever begin
        @(posedge cs_n);
        if (rx_bits == DW) begin
            recv_data = rx_shift;
            rx_q.push_back(rx_shift);
            len_q.push_back(int'(($time - t_fall) / 10));
        end
        rx_bits = 0;
    end

    // Reference model: queue holds FIFO contents; a tick fires every SP enabled cycles.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] exp_q[$];
    int            m_tick       = 0;
    logic          exp_tready   = 1'b0;
    logic          exp_irq      = 1'b0;
    logic          exp_underrun = 1'b0;
    bit            chk_en       = 1'b0;
    bit            m_push, m_tk;

    initial forever begin
        @(posedge aclk);
        if (areset === 1'b1) begin
            m_q.delete();
            m_tick       = 0;
            exp_tready   = 1'b0;
            exp_irq      = 1'b0;
            exp_underrun = 1'b0;
            chk_en       = 1'b1;
        end else if (chk_en) begin
            m_push       = (tvalid === 1'b1) && (tready === 1'b1);
            m_tk         = en && (m_tick == SP - 1);
            exp_irq      = en && (m_q.size() <= LT);
            exp_underrun = m_tk && (m_q.size() == 0);
            if (m_tk && m_q.size() > 0) exp_q.push_back(xform(m_q.pop_front()));
            if (m_push) m_q.push_back(tdata);
            exp_tready   = (m_q.size() != DEPTH);
            m_tick       = (!en || m_tk) ? 0 : m_tick + 1;
        end
    end

    initial forever begin
        @(negedge aclk);
        if (chk_en) begin
            chk("tready", {31'b0, tready}, {31'b0, exp_tready});
            chk("fifo_irq", {31'b0, fifo_irq}, {31'b0, exp_irq});
            chk("underrun", {31'b0, underrun}, {31'b0, exp_underrun});
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic push_one(input logic [DW-1:0] d);
        int k = 0;
        tvalid = 1'b1;
        tdata  = d;
        while (tready !== 1'b1 && k < 100) begin
            step();
            k++;
        end
        chk("push_ready", {31'b0, tready}, 32'd1);
        step();
        tvalid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("frame_count", rx_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (rx_q.size() > 0 && exp_q.size() > 0) begin
                chk("frame_data", {16'b0, rx_q.pop_front()}, {16'b0, exp_q.pop_front()});
                chk("cs_low_cycles", len_q.pop_front(), 32 * CD);
            end
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy !== 1'b0 && k < SP) begin
            step();
            k++;
        end
        chk("idle", {31'b0, busy}, 32'd0);
    endtask

    task automatic wait_underrun();
        int k = 0;
        while (underrun !== 1'b1 && k < SP + 10) begin
            step();
            k++;
        end
        chk("underrun_seen", {31'b0, underrun}, 32'd1);
    endtask

    initial begin
        int            accepted;
        int            k;
        int            rxn;
        logic [DW-1:0] prev;

        areset = 1'b1;
        en     = 1'b0;
        tvalid = 1'b0;
        tdata  = '0;
        repeat (5) step();
        chk("rst_cs_n", {31'b0, cs_n}, 32'd1);
        chk("rst_sclk", {31'b0, sclk}, 32'd0);
        chk("rst_sdi", {31'b0, sdi}, 32'd0);
        chk("rst_tready", {31'b0, tready}, 32'd0);
        chk("rst_irq", {31'b0, fifo_irq}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);

        areset = 1'b0;
        en     = 1'b1;
        step();
        chk("release_tready", {31'b0, tready}, 32'd1);
        step();
        chk("release_irq", {31'b0, fifo_irq}, 32'd1);

        push_one(16'hA5C3);
        wait_frames(1, 3 * SP);
        chk("recv_a5c3", {16'b0, recv_data}, {16'b0, xform(16'hA5C3)});
        wait_idle();

        push_one(16'h0000);
        push_one(16'h8000);
        wait_frames(2, 4 * SP);
        wait_idle();

        for (int i = 0; i < 6; i++) push_one(DW'($urandom));
        wait_frames(6, 8 * SP);
        wait_idle();

        // Back-pressure: no ticks while 20 samples are offered.
        en       = 1'b0;
        tvalid   = 1'b1;
        accepted = 0;
        for (int i = 0; i < 40 && accepted < 20; i++) begin
            tdata = DW'($urandom);
            if (tready === 1'b1) accepted++;
            step();
        end
        tvalid = 1'b0;
        chk("bp_accepted", accepted, 16);
        chk("bp_tready_low", {31'b0, tready}, 32'd0);

        en = 1'b1;
        wait_frames(16, 17 * SP + 50);
        wait_underrun();

        // Refill burst: count 0 -> 5 must clear the low interrupt.
        for (int i = 0; i < 5; i++) push_one(DW'($urandom));
        step();
        chk("irq_clear_at_5", {31'b0, fifo_irq}, 32'd0);
        wait_frames(5, 6 * SP);
        wait_idle();

        // Abort a frame during the 8th sclk high phase.
        push_one(DW'($urandom));
        k = 0;
        while (cs_n !== 1'b0 && k < SP + 10) begin
            step();
            k++;
        end
        k = 0;
        while (rises < 8 && k < 100) begin
            step();
            k++;
        end
        chk("abort_rises", rises, 8);
        chk("abort_sclk_high", {31'b0, sclk}, 32'd1);
        rxn    = rx_q.size();
        prev   = recv_data;
        areset = 1'b1;
        step();
        chk("abort_cs_n", {31'b0, cs_n}, 32'd1);
        chk("abort_sclk", {31'b0, sclk}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        areset = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        step();
        step();
        chk("abort_no_frame", rx_q.size(), rxn);
        chk("abort_recv_hold", {16'b0, recv_data}, {16'b0, prev});
        wait_underrun();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
